async_reset_reg_pipe: RTL and testbench

// Parametrised multi-bit, multi-stage register pipeline. Every flop is

---
 rtl/async_reset_reg_pipe.sv | 100 ++++++++++
 tb/tb_async_reset_reg_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/async_reset_reg_pipe.sv
// Enabled register delay line with per-stage valid tags and a priming flag.
// Every flop resets asynchronously; clr empties the pipe synchronously.
module async_reset_reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [CW-1:0]    valid_cnt,
  output logic             primed
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             primed_q;
  logic             primed_d;

  // Data and tag next state: clear beats shift, shift beats hold.
  always_comb begin
    stage_d = stage_q;
    vld_d   = vld_q;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = RESET_VALUE;
      end
      vld_d = '0;
    end else if (en) begin
      stage_d[0] = d;
      vld_d[0]   = d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
        vld_d[i]   = vld_q[i-1];
      end
    end
  end

  // Priming counter saturates at DEPTH so it never wraps back to unprimed.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != FULL)) begin
      cnt_d = cnt_q + 1'b1;
    end
    primed_d = (cnt_d == FULL);
  end

  // Data stage registers with asynchronous reset to the programmed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Valid tags, priming counter and primed flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  // Popcount of the tags; CW is sized to hold DEPTH itself.
  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_cnt = valid_cnt + CW'(vld_q[i]);
    end
  end

  assign q       = stage_q[DEPTH-1];
  assign q_valid = vld_q[DEPTH-1];
  assign primed  = primed_q;

endmodule

// File: tb/tb_async_reset_reg_pipe.sv
// Scoreboard bench for async_reset_reg_pipe at DEPTH 3, 1 and 7.
// All three pipes share stimulus; each has its own expectation queue.
module tb_async_reset_reg_pipe;

  typedef struct packed {
    logic [7:0]  data;
    logic        vld;
    logic [31:0] due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] d = 8'h00;
  logic       d_valid = 1'b0;

  logic [7:0] q3, q1, q7;
  logic       qv3, qv1, qv7;
  logic [1:0] vc3;
  logic [0:0] vc1;
  logic [2:0] vc7;
  logic       pr3, pr1, pr7;

  int n_chk = 0;
  int n_fail = 0;
  int unsigned en_cnt = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];
  logic [7:0] last_q [3];
  logic       last_v [3];

  always #5 clk = ~clk;

  async_reset_reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5)) u3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q3), .q_valid(qv3), .valid_cnt(vc3), .primed(pr3));

  async_reset_reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(8'h3C)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q1), .q_valid(qv1), .valid_cnt(vc1), .primed(pr1));

  async_reset_reg_pipe #(.WIDTH(8), .DEPTH(7), .RESET_VALUE(8'h5A)) u7 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_valid(d_valid),
    .q(q7), .q_valid(qv7), .valid_cnt(vc7), .primed(pr7));

  function automatic int dep(input int k);
    case (k)
      0: return 3;
      1: return 1;
      default: return 7;
    endcase
  endfunction

  function automatic logic [7:0] rv(input int k);
    case (k)
      0: return 8'hA5;
      1: return 8'h3C;
      default: return 8'h5A;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_empty();
    sb0.delete();
    sb1.delete();
    sb2.delete();
    en_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      last_q[k] = rv(k);
      last_v[k] = 1'b0;
    end
  endtask

  task automatic push_all(input logic [7:0] dd, input logic dv);
    exp_t e;
    e.data = dd;
    e.vld  = dv;
    e.due  = en_cnt + 3;
    sb0.push_back(e);
    e.due  = en_cnt + 1;
    sb1.push_back(e);
    e.due  = en_cnt + 7;
    sb2.push_back(e);
  endtask

  task automatic score(input int k, input string ph);
    exp_t e;
    logic [7:0]  gq;
    logic        gv;
    logic [31:0] gc;
    logic        gp;
    int          vc;
    gq = '0; gv = 1'b0; gc = '0; gp = 1'b0;
    case (k)
      0: begin
        gq = q3; gv = qv3; gc = 32'(vc3); gp = pr3;
        if (sb0.size() != 0 && sb0[0].due == en_cnt) begin
          e = sb0.pop_front();
          last_q[k] = e.data;
          last_v[k] = e.vld;
        end
      end
      1: begin
        gq = q1; gv = qv1; gc = 32'(vc1); gp = pr1;
        if (sb1.size() != 0 && sb1[0].due == en_cnt) begin
          e = sb1.pop_front();
          last_q[k] = e.data;
          last_v[k] = e.vld;
        end
      end
      default: begin
        gq = q7; gv = qv7; gc = 32'(vc7); gp = pr7;
        if (sb2.size() != 0 && sb2[0].due == en_cnt) begin
          e = sb2.pop_front();
          last_q[k] = e.data;
          last_v[k] = e.vld;
        end
      end
    endcase
    vc = int'(last_v[k]);
    case (k)
      0: foreach (sb0[i]) vc += int'(sb0[i].vld);
      1: foreach (sb1[i]) vc += int'(sb1[i].vld);
      default: foreach (sb2[i]) vc += int'(sb2[i].vld);
    endcase
    chk($sformatf("%s_d%0d_q", ph, dep(k)), 32'(gq), 32'(last_q[k]));
    chk($sformatf("%s_d%0d_qv", ph, dep(k)), 32'(gv), 32'(last_v[k]));
    chk($sformatf("%s_d%0d_vcnt", ph, dep(k)), gc, 32'(vc));
    chk($sformatf("%s_d%0d_primed", ph, dep(k)), 32'(gp),
        32'(en_cnt >= 32'(dep(k))));
  endtask

  task automatic score_all(input string ph);
    for (int k = 0; k < 3; k++) score(k, ph);
  endtask

  task automatic cyc(input logic e, input logic [7:0] dd,
                     input logic dv, input logic c, input string ph);
    @(negedge clk);
    en = e;
    d = dd;
    d_valid = dv;
    clr = c;
    if (c) model_empty();
    else if (e) push_all(dd, dv);
    @(posedge clk);
    #1;
    if (!c && e) en_cnt++;
    score_all(ph);
  endtask

  task automatic async_rst(input string ph);
    #2;
    rst = 1'b1;
    #1;
    model_empty();
    score_all(ph);
    @(negedge clk);
    en = 1'b0;
    clr = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    // Reset pulse with no clock edge in between.
    #2;
    rst = 1'b1;
    #1;
    model_empty();
    score_all("rst0");
    @(negedge clk);
    rst = 1'b0;

    // Straight fill with valid data.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0, "fill");

    // Stall in the middle: 7 enters, five idle cycles, two more enables.
    cyc(1'b1, 8'h07, 1'b1, 1'b0, "stall");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 8'($urandom), 1'b1, 1'b0, "stall");
    cyc(1'b1, 8'h08, 1'b0, 1'b0, "stall");
    cyc(1'b1, 8'h09, 1'b1, 1'b0, "stall");
    chk("stall_d3_seven", 32'(q3), 32'h07);

    // Full pipe then clr together with en.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0, "pre");
    chk("full_d7_vcnt7", 32'(vc7), 32'd7);
    cyc(1'b1, 8'h09, 1'b1, 1'b1, "clr");
    chk("clr_d3_q", 32'(q3), 32'hA5);

    // Async reset between edges with the pipe full, then refill.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0, "pre2");
    async_rst("arst");
    for (int i = 0; i < 9; i++)
      cyc(1'b1, 8'h80 + 8'(i), 1'($urandom_range(0, 1)), 1'b0, "refill");

    // Random traffic with occasional clear and one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) async_rst("rnd_rst");
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
